// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin req/ack sequencer for a single-port async-read data memory
// Define ARB_LOCK_EN to add lock0/lock1 ownership for atomic read-modify-write sequences.
module data_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
`ifdef ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_w,
  input  logic [DW-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_next;
  logic            start;
  logic            sel;
  logic            grant;
  logic            last_grant;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
`ifdef ARB_LOCK_EN
  logic            owner_valid;
  logic            owner;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start       = 1'b0;
    sel         = 1'b0;
    busy        = (state != IDLE);
    ack0        = 1'b0;
    ack1        = 1'b0;
    mem_w       = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    case (state)
      IDLE: begin
`ifdef ARB_LOCK_EN
        if (owner_valid) begin
          // a lock owner excludes the other requester even on a tie
          sel   = owner;
          start = owner ? req1 : req0;
        end else
`endif
        begin
          sel   = (req0 && req1) ? ~last_grant : req1;
          start = req0 | req1;
        end
        if (start) state_next = ACCESS;
      end
      ACCESS: begin
        mem_w       = lat_we;
        mem_address = lat_addr;
        mem_data_in = lat_wdata;
        state_next  = DONE;
      end
      DONE: begin
        ack0       = ~grant;
        ack1       = grant;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rdata       <= '0;
`ifdef ARB_LOCK_EN
      owner_valid <= 1'b0;
      owner       <= 1'b0;
`endif
    end else begin
      if (start) begin
        grant     <= sel;
        lat_we    <= sel ? we1    : we0;
        lat_addr  <= sel ? addr1  : addr0;
        lat_wdata <= sel ? wdata1 : wdata0;
`ifdef ARB_LOCK_EN
        owner_valid <= sel ? lock1 : lock0;
        owner       <= sel;
`endif
      end
      if (state == ACCESS) begin
        last_grant <= grant;
        if (!lat_we) rdata <= mem_data_out;
      end
    end
  end

endmodule
